tft_frame_streamer: RTL and testbench

- Downstream consumer of the on-chip 32-bit × 1024-word frame memory.
- On a start pulse, it issues the TFT memory-write command.
- It then reads a contiguous word range from the memory's single port, at 1-cycle read latency.
- Each 32-bit word is split into two RGB565 pixels and written to an 8080-style 16-bit TFT bus with programmable write-strobe timing.

---
 rtl/tft_pkg.sv | 24 ++
 rtl/tft_frame_streamer_if.sv | 31 +++
 rtl/tft_wr_strobe.sv | 68 ++++++
 rtl/tft_frame_streamer.sv | 160 ++++++++++++++++
 tb/tb_tft_frame_streamer.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tft_pkg.sv
// Shared types for the TFT frame streamer: FSM states, the default memory-write
// command and the RGB565 pixel type.
package tft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        WAIT,
        PIX_LO,
        PIX_HI,
        DONE
    } state_e;

    localparam logic [15:0] CMD_MEMWR_DEFAULT = 16'h002C;

    typedef logic [15:0] rgb565_t;

    // Big-endian panels expect the two bytes of each pixel halfword exchanged.
    function automatic rgb565_t swap_bytes(input rgb565_t d);
        return {d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/tft_frame_streamer_if.sv
// Control, frame-memory read port and 8080-style TFT bus of the frame streamer.
// master = the streamer, slave = the surrounding system (memory, panel, requester).
interface tft_frame_streamer_if #(
    parameter int ADDR_W = 10
);
    import tft_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic [31:0]       mem_readdata;
    logic              tft_cs_n;
    logic              tft_rs;
    logic              tft_wr_n;
    rgb565_t           tft_data;

    modport master (
        input  start, mem_readdata,
        output busy, done, mem_address, mem_chipselect,
        output tft_cs_n, tft_rs, tft_wr_n, tft_data
    );

    modport slave (
        output start, mem_readdata,
        input  busy, done, mem_address, mem_chipselect,
        input  tft_cs_n, tft_rs, tft_wr_n, tft_data
    );

endinterface

// File: rtl/tft_wr_strobe.sv
// One 8080 bus write per go pulse: wr_n low for WR_LOW cycles, then high for WR_HIGH
// cycles with rs/data held; last_o marks the final high cycle so writes can chain.
module tft_wr_strobe
    import tft_pkg::*;
#(
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    go_i,
    input  logic    rs_i,
    input  rgb565_t data_i,
    output logic    wr_n_o,
    output logic    rs_o,
    output rgb565_t data_o,
    output logic    last_o
);

    localparam int MAX_PHASE = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int CNT_W     = $clog2(MAX_PHASE) + 1;
    localparam logic [CNT_W-1:0] LOW_END  = CNT_W'(WR_LOW - 1);
    localparam logic [CNT_W-1:0] HIGH_END = CNT_W'(WR_HIGH - 1);

    logic             active_q;
    logic             wr_n_q;
    logic             rs_q;
    rgb565_t          data_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            wr_n_q   <= 1'b1;
            rs_q     <= 1'b1;
            data_q   <= '0;
            cnt_q    <= '0;
        end else if (go_i) begin
            // rs/data only ever change together with the falling strobe.
            active_q <= 1'b1;
            wr_n_q   <= 1'b0;
            rs_q     <= rs_i;
            data_q   <= data_i;
            cnt_q    <= '0;
        end else if (active_q) begin
            if (!wr_n_q) begin
                if (cnt_q == LOW_END) begin
                    wr_n_q <= 1'b1;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (cnt_q == HIGH_END) begin
                active_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign wr_n_o = wr_n_q;
    assign rs_o   = rs_q;
    assign data_o = data_q;
    assign last_o = active_q && wr_n_q && (cnt_q == HIGH_END);

endmodule

// File: rtl/tft_frame_streamer.sv
// Streams a word range of the frame memory to an 8080 TFT bus as RGB565 pixel pairs,
// preceded by the memory-write command. Define TFT_BYTE_SWAP_EN to byte-swap pixels.
module tft_frame_streamer
    import tft_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          BASE_WORD = 0,
    parameter int          NUM_WORDS = 1024,
    parameter int          WR_LOW    = 2,
    parameter int          WR_HIGH   = 2,
    parameter logic [15:0] CMD_MEMWR = CMD_MEMWR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tft_frame_streamer_if.master bus
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] BASE_EXT = CNT_W'(BASE_WORD);

`ifdef TFT_BYTE_SWAP_EN
    function automatic rgb565_t pix_fmt(input rgb565_t p);
        return swap_bytes(p);
    endfunction
`else
    function automatic rgb565_t pix_fmt(input rgb565_t p);
        return p;
    endfunction
`endif

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] sum;
        sum = BASE_EXT + cnt;
        return sum[ADDR_W-1:0];
    endfunction

    state_e            state_q;
    logic [CNT_W-1:0]  word_cnt_q;
    rgb565_t           hi_pix_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic              mem_cs_q;
    logic              busy_q;
    logic              done_q;
    logic              cs_n_q;

    logic    go_d;
    logic    rs_d;
    rgb565_t data_d;
    logic    strobe_last;

    // Writes are launched in the cycle before the strobe falls so that chained
    // writes (CMD, PIX_LO -> PIX_HI) keep exactly WR_LOW+WR_HIGH cycles each.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        go_d   = 1'b0;
        rs_d   = 1'b1;
        data_d = CMD_MEMWR;
        case (state_q)
            IDLE: begin
                go_d = bus.start;
                rs_d = 1'b0;
            end
            WAIT: begin
                go_d   = 1'b1;
                data_d = pix_fmt(bus.mem_readdata[15:0]);
            end
            PIX_LO: begin
                go_d   = strobe_last;
                data_d = hi_pix_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            hi_pix_q      <= '0;
            mem_address_q <= '0;
            mem_cs_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cs_n_q        <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= CMD;
                        busy_q     <= 1'b1;
                        cs_n_q     <= 1'b0;
                        word_cnt_q <= '0;
                    end
                end
                CMD: begin
                    if (strobe_last) begin
                        state_q       <= FETCH;
                        mem_address_q <= addr_of(word_cnt_q);
                        mem_cs_q      <= 1'b1;
                    end
                end
                FETCH: begin
                    state_q  <= WAIT;
                    mem_cs_q <= 1'b0;
                end
                WAIT: begin
                    // The low half goes straight to the strobe; only the high half waits.
                    hi_pix_q <= pix_fmt(bus.mem_readdata[31:16]);
                    state_q  <= PIX_LO;
                end
                PIX_LO: begin
                    if (strobe_last) state_q <= PIX_HI;
                end
                PIX_HI: begin
                    if (strobe_last) begin
                        if (word_cnt_q == LAST_CNT) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            cs_n_q  <= 1'b1;
                        end else begin
                            state_q       <= FETCH;
                            word_cnt_q    <= word_cnt_q + 1'b1;
                            mem_address_q <= addr_of(word_cnt_q + 1'b1);
                            mem_cs_q      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    tft_wr_strobe #(
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH)
    ) u_wr_strobe (
        .clk     (clk),
        .reset_n (reset_n),
        .go_i    (go_d),
        .rs_i    (rs_d),
        .data_i  (data_d),
        .wr_n_o  (bus.tft_wr_n),
        .rs_o    (bus.tft_rs),
        .data_o  (bus.tft_data),
        .last_o  (strobe_last)
    );

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_chipselect = mem_cs_q;
    assign bus.tft_cs_n       = cs_n_q;

endmodule

// File: tb/tb_tft_frame_streamer.sv
// Bench for tft_frame_streamer: four differently parameterised instances share one
// frame memory; bus writes are scoreboarded and strobe widths checked per cycle.
module tb_tft_frame_streamer;

    localparam int NDUT = 4;

    logic        clk;
    logic        reset_n;
    logic        start_r [NDUT];
    logic [31:0] mem [1024];

    wire         busy_w  [NDUT];
    wire         done_w  [NDUT];
    wire         cs_n_w  [NDUT];
    wire         rs_w    [NDUT];
    wire         wr_n_w  [NDUT];
    wire         mcs_w   [NDUT];
    wire [9:0]   addr_w  [NDUT];
    wire [15:0]  data_w  [NDUT];

    int checks   = 0;
    int failures = 0;

    function automatic int base_of(input int g);
        return (g == 2) ? 1022 : 0;
    endfunction
    function automatic int nw_of(input int g);
        case (g)
            1:       return 1;
            3:       return 1024;
            default: return 2;
        endcase
    endfunction
    function automatic int wl_of(input int g);
        return (g == 1) ? 1 : 2;
    endfunction
    function automatic int wh_of(input int g);
        return (g == 1) ? 3 : 2;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        tft_frame_streamer_if #(.ADDR_W(10)) bus ();
        logic [31:0] rdata_q;

        always @(posedge clk) if (bus.mem_chipselect) rdata_q <= mem[bus.mem_address];

        assign bus.start        = start_r[g];
        assign bus.mem_readdata = rdata_q;
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;
        assign cs_n_w[g] = bus.tft_cs_n;
        assign rs_w[g]   = bus.tft_rs;
        assign wr_n_w[g] = bus.tft_wr_n;
        assign mcs_w[g]  = bus.mem_chipselect;
        assign addr_w[g] = bus.mem_address;
        assign data_w[g] = bus.tft_data;

        tft_frame_streamer #(
            .ADDR_W    (10),
            .BASE_WORD (base_of(g)),
            .NUM_WORDS (nw_of(g)),
            .WR_LOW    (wl_of(g)),
            .WR_HIGH   (wh_of(g))
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        logic [15:0] iv;
        iv = 16'(i);
        case (i)
            0:       return 32'h1234ABCD;
            1:       return 32'h5678EF01;
            default: return {iv ^ 16'hA5A5, iv + 16'h3C00};
        endcase
    endfunction

    function automatic logic [15:0] exp_pix(input logic [15:0] x);
`ifdef TFT_BYTE_SWAP_EN
        return {x[7:0], x[15:8]};
`else
        return x;
`endif
    endfunction

    // Scoreboard of {rs, data} bus writes and log of memory read addresses.
    logic [16:0] exp_q [$];
    logic [9:0]  addr_log [$];

    task automatic push_frame(input int base, input int nw);
        logic [31:0] x;
        exp_q.push_back({1'b0, 16'h002C});
        for (int w = 0; w < nw; w++) begin
            x = word_at(base + w);
            exp_q.push_back({1'b1, exp_pix(x[15:0])});
            exp_q.push_back({1'b1, exp_pix(x[31:16])});
        end
    endtask

    // Monitor for the selected instance, sampled on the falling clock edge.
    int          sel = 0;
    int          low_len = 0;
    int          high_len = 1000;
    logic        prev_wr_n = 1'b1;
    logic        after_lo = 1'b0;
    logic [16:0] held = '0;
    int          cmd_seen = 0;
    int          pix_seen = 0;

    always @(negedge clk) begin
        logic        cur;
        logic [16:0] d;
        logic [16:0] e;
        if (!reset_n) begin
            prev_wr_n = 1'b1;
            after_lo  = 1'b0;
            high_len  = 1000;
        end else begin
            cur = wr_n_w[sel];
            d   = {rs_w[sel], data_w[sel]};
            if (mcs_w[sel]) addr_log.push_back(addr_w[sel]);
            if (!cur && prev_wr_n) begin
                check("high_gap", after_lo ? (high_len == wh_of(sel)) : (high_len >= wh_of(sel)), 1);
                low_len = 1;
                held    = d;
            end else if (!cur) begin
                low_len++;
                check("low_stable", d, held);
            end else if (!prev_wr_n) begin
                check("low_width", low_len, wl_of(sel));
                check("rise_stable", d, held);
                check("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_write", d, e);
                end
                if (d[16]) pix_seen++;
                else cmd_seen++;
                after_lo = d[16] ? ~after_lo : 1'b0;
                high_len = 1;
            end else begin
                if (high_len < wh_of(sel)) check("high_stable", d, held);
                high_len++;
            end
            prev_wr_n = cur;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Start pulse in the current cycle (cycle 0); returns in cycle 1.
    task automatic start_frame(input int g);
        start_r[g] = 1'b1;
        next_cycle();
        start_r[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int bound, output int cyc);
        cyc = 1;
        while (!done_w[g] && cyc < bound) begin
            next_cycle();
            cyc++;
        end
    endtask

    typedef struct {
        int          cyc;
        logic        start_in;
        logic        busy;
        logic        done;
        logic        cs_n;
        logic        wr_n;
        logic        mcs;
        logic        chk_bus;
        logic        rs;
        logic [9:0]  addr;
        logic [15:0] data;
    } vec_t;

    // flags = {start, busy, done, cs_n, wr_n, mem_cs, check rs/data, rs}
    function automatic vec_t mk(input int c, input logic [7:0] f, input logic [9:0] a,
                                input logic [15:0] dat);
        vec_t v;
        v.cyc = c;  v.start_in = f[7]; v.busy = f[6]; v.done = f[5]; v.cs_n = f[4];
        v.wr_n = f[3]; v.mcs = f[2]; v.chk_bus = f[1]; v.rs = f[0];
        v.addr = a; v.data = dat;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        int vi;
        int c;
        vecs = '{
            mk(0,  8'b1_0_0_1_1_0_1_1, 10'd0, 16'h0000),
            mk(1,  8'b0_1_0_0_0_0_1_0, 10'd0, 16'h002C),
            mk(3,  8'b0_1_0_0_1_0_1_0, 10'd0, 16'h002C),
            mk(5,  8'b0_1_0_0_1_1_1_0, 10'd0, 16'h002C),
            mk(6,  8'b0_1_0_0_1_0_1_0, 10'd0, 16'h002C),
            mk(7,  8'b0_1_0_0_0_0_1_1, 10'd0, exp_pix(16'hABCD)),
            mk(10, 8'b1_1_0_0_1_0_1_1, 10'd0, exp_pix(16'hABCD)),
            mk(11, 8'b0_1_0_0_0_0_1_1, 10'd0, exp_pix(16'h1234)),
            mk(15, 8'b0_1_0_0_1_1_1_1, 10'd1, exp_pix(16'h1234)),
            mk(17, 8'b0_1_0_0_0_0_1_1, 10'd0, exp_pix(16'hEF01)),
            mk(21, 8'b0_1_0_0_0_0_1_1, 10'd0, exp_pix(16'h5678)),
            mk(24, 8'b0_1_0_0_1_0_1_1, 10'd0, exp_pix(16'h5678)),
            mk(25, 8'b1_0_1_1_1_0_0_1, 10'd0, 16'h0000),
            mk(26, 8'b1_0_0_1_1_0_0_1, 10'd0, 16'h0000),
            mk(27, 8'b0_1_0_0_0_0_1_0, 10'd0, 16'h002C)
        };

        for (int i = 0; i < 1024; i++) mem[i] = word_at(i);
        for (int g = 0; g < NDUT; g++) start_r[g] = 1'b0;
        reset_n = 1'b0;
        #23;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("rst%0d_busy", g), busy_w[g], 0);
            check($sformatf("rst%0d_done", g), done_w[g], 0);
            check($sformatf("rst%0d_cs_n", g), cs_n_w[g], 1);
            check($sformatf("rst%0d_wr_n", g), wr_n_w[g], 1);
            check($sformatf("rst%0d_rs", g), rs_w[g], 1);
            check($sformatf("rst%0d_data", g), data_w[g], 0);
            check($sformatf("rst%0d_mcs", g), mcs_w[g], 0);
            check($sformatf("rst%0d_addr", g), addr_w[g], 0);
        end
        reset_n = 1'b1;
        next_cycle();

        // Basic stream, a start while busy, a start in DONE and one right after it.
        sel = 0;
        vi  = 0;
        for (int k = 0; k <= 27; k++) begin
            start_r[0] = 1'b0;
            if (vi < 15 && vecs[vi].cyc == k) begin
                start_r[0] = vecs[vi].start_in;
                check($sformatf("vec%0d_busy", k), busy_w[0], vecs[vi].busy);
                check($sformatf("vec%0d_done", k), done_w[0], vecs[vi].done);
                check($sformatf("vec%0d_cs_n", k), cs_n_w[0], vecs[vi].cs_n);
                check($sformatf("vec%0d_wr_n", k), wr_n_w[0], vecs[vi].wr_n);
                check($sformatf("vec%0d_mcs", k), mcs_w[0], vecs[vi].mcs);
                if (vecs[vi].mcs) check($sformatf("vec%0d_addr", k), addr_w[0], vecs[vi].addr);
                if (vecs[vi].chk_bus) begin
                    check($sformatf("vec%0d_rs", k), rs_w[0], vecs[vi].rs);
                    check($sformatf("vec%0d_data", k), data_w[0], vecs[vi].data);
                end
                vi++;
            end
            if (k == 0 || k == 26) push_frame(0, 2);
            next_cycle();
        end
        start_r[0] = 1'b0;
        check("frameA_cmd_count", cmd_seen, 1);
        c = 28;
        while (!done_w[0] && c < 100) begin
            next_cycle();
            c++;
        end
        check("frameB_done_cycle", c, 51);
        next_cycle();
        check("frameB_cmd_count", cmd_seen, 2);
        check("frameB_sb_empty", exp_q.size(), 0);

        // Reset during the PIX_HI low phase of the first word.
        exp_q.push_back({1'b0, 16'h002C});
        exp_q.push_back({1'b1, exp_pix(16'hABCD)});
        start_frame(0);
        for (int i = 1; i < 11; i++) next_cycle();
        check("pre_reset_wr_n", wr_n_w[0], 0);
        reset_n = 1'b0;
        #1;
        check("async_rst_wr_n", wr_n_w[0], 1);
        check("async_rst_cs_n", cs_n_w[0], 1);
        check("async_rst_busy", busy_w[0], 0);
        check("async_rst_mcs", mcs_w[0], 0);
        next_cycle();
        next_cycle();
        check("aborted_sb_empty", exp_q.size(), 0);
        reset_n = 1'b1;
        next_cycle();
        push_frame(0, 2);
        start_frame(0);
        wait_done(0, 100, c);
        check("post_reset_done_cycle", c, 25);
        next_cycle();
        check("post_reset_sb_empty", exp_q.size(), 0);

        // Strobe timing with WR_LOW=1, WR_HIGH=3, one word.
        sel = 1;
        push_frame(0, 1);
        start_frame(1);
        wait_done(1, 100, c);
        check("strobe_done_cycle", c, 15);
        next_cycle();
        check("strobe_sb_empty", exp_q.size(), 0);

        // Top-of-memory range: words 1022 and 1023 only.
        sel = 2;
        addr_log.delete();
        push_frame(1022, 2);
        start_frame(2);
        wait_done(2, 100, c);
        check("range_done_cycle", c, 25);
        next_cycle();
        check("range_sb_empty", exp_q.size(), 0);
        check("range_access_count", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            check("range_addr0", addr_log[0], 1022);
            check("range_addr1", addr_log[1], 1023);
        end

        // Full 1024-word frame.
        sel = 3;
        addr_log.delete();
        pix_seen = 0;
        push_frame(0, 1024);
        start_frame(3);
        wait_done(3, 11000, c);
        check("full_done_cycle", c, 10245);
        next_cycle();
        check("full_pixel_writes", pix_seen, 2048);
        check("full_sb_empty", exp_q.size(), 0);
        check("full_access_count", addr_log.size(), 1024);
        if (addr_log.size() == 1024) begin
            for (int i = 0; i < 1024; i++) check($sformatf("full_addr%0d", i), addr_log[i], i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
